// File: rtl/mandelbrot_iter_unit.sv
// Mandelbrot escape-time iterator with radix-4 serial multipliers.
// MANDEL_OVF_ESCAPE_EN: overflow of z ends the job as escaped instead of saturating.
module mandelbrot_iter_unit #(
  parameter int WIDTH  = 12,
  parameter int FRAC   = WIDTH - 3,
  parameter int ITER_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_cr,
  input  logic [WIDTH-1:0]  in_ci,
  input  logic [ITER_W-1:0] in_max_iter,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ITER_W-1:0] out_iter,
  output logic              out_escaped,
  output logic              busy
);

  localparam int MC = (WIDTH + 1) / 2;
  localparam int PW = 2 * WIDTH;
  localparam int EW = 2 * MC;
  localparam int IW = WIDTH + 3;
  localparam int CW = $clog2(MC + 1);
  localparam logic [PW:0] FOUR = (PW + 1)'(1) << (2 * FRAC + 2);
  localparam logic signed [WIDTH-1:0] ZMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] ZMIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_MULT,
    S_UPDATE,
    S_DONE
  } state_t;

  state_t                   r_state;
  logic signed [WIDTH-1:0]  r_cr;
  logic signed [WIDTH-1:0]  r_ci;
  logic [ITER_W-1:0]        r_max;
  logic signed [WIDTH-1:0]  r_zr;
  logic signed [WIDTH-1:0]  r_zi;
  logic [ITER_W-1:0]        r_n;
  logic signed [EW-1:0]     r_sr;
  logic signed [EW-1:0]     r_si;
  logic [CW-1:0]            r_cnt;
  logic signed [PW-1:0]     r_prr;
  logic signed [PW-1:0]     r_pii;
  logic signed [PW-1:0]     r_pri;
  logic                     r_in_ready;
  logic                     r_out_valid;
  logic [ITER_W-1:0]        r_out_iter;
  logic                     r_out_escaped;
  logic                     r_busy;

  // One radix-4 partial product; the top digit carries the sign bit.
  function automatic logic signed [PW-1:0] f_pp(
    input logic signed [WIDTH-1:0] a,
    input logic [1:0]              d,
    input logic                    last
  );
    logic signed [PW-1:0] ax;
    ax = PW'(a);
    f_pp = '0;
    unique case (d)
      2'd0: f_pp = '0;
      2'd1: f_pp = ax;
      2'd2: f_pp = last ? -(ax <<< 1) : (ax <<< 1);
      2'd3: f_pp = last ? -ax : ax + (ax <<< 1);
    endcase
  endfunction

  logic                    w_last;
  logic [PW:0]             w_mag;
  logic signed [PW:0]      w_diff;
  logic signed [PW:0]      w_ri2;
  logic signed [IW-1:0]    w_tr;
  logic signed [IW-1:0]    w_ti;
  logic                    w_ovr;
  logic                    w_ovi;
  logic signed [WIDTH-1:0] w_nzr;
  logic signed [WIDTH-1:0] w_nzi;
  logic [ITER_W-1:0]       w_n1;

  assign w_last = (r_cnt == CW'(MC - 1));
  assign w_mag  = (PW + 1)'($unsigned(r_prr)) + (PW + 1)'($unsigned(r_pii));
  assign w_diff = (PW + 1)'(r_prr) - (PW + 1)'(r_pii);
  assign w_ri2  = (PW + 1)'(r_pri) <<< 1;
  assign w_tr   = IW'(w_diff >>> FRAC) + IW'(r_cr);
  assign w_ti   = IW'(w_ri2 >>> FRAC) + IW'(r_ci);
  assign w_ovr  = !((&w_tr[IW-1:WIDTH-1]) || !(|w_tr[IW-1:WIDTH-1]));
  assign w_ovi  = !((&w_ti[IW-1:WIDTH-1]) || !(|w_ti[IW-1:WIDTH-1]));
  assign w_nzr  = w_ovr ? (w_tr[IW-1] ? ZMIN : ZMAX) : w_tr[WIDTH-1:0];
  assign w_nzi  = w_ovi ? (w_ti[IW-1] ? ZMIN : ZMAX) : w_ti[WIDTH-1:0];
  assign w_n1   = r_n + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cr          <= '0;
      r_ci          <= '0;
      r_max         <= '0;
      r_zr          <= '0;
      r_zi          <= '0;
      r_n           <= '0;
      r_sr          <= '0;
      r_si          <= '0;
      r_cnt         <= '0;
      r_prr         <= '0;
      r_pii         <= '0;
      r_pri         <= '0;
      r_in_ready    <= 1'b1;
      r_out_valid   <= 1'b0;
      r_out_iter    <= '0;
      r_out_escaped <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_cr       <= in_cr;
            r_ci       <= in_ci;
            r_max      <= in_max_iter;
            r_zr       <= '0;
            r_zi       <= '0;
            r_n        <= '0;
            r_sr       <= '0;
            r_si       <= '0;
            r_cnt      <= '0;
            r_prr      <= '0;
            r_pii      <= '0;
            r_pri      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_MULT;
          end
        end
        S_MULT: begin
          r_prr <= r_prr + (f_pp(r_zr, r_sr[1:0], w_last) <<< {r_cnt, 1'b0});
          r_pii <= r_pii + (f_pp(r_zi, r_si[1:0], w_last) <<< {r_cnt, 1'b0});
          r_pri <= r_pri + (f_pp(r_zr, r_si[1:0], w_last) <<< {r_cnt, 1'b0});
          r_sr  <= r_sr >>> 2;
          r_si  <= r_si >>> 2;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_state <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          r_cnt <= '0;
          r_prr <= '0;
          r_pii <= '0;
          r_pri <= '0;
          if (w_mag > FOUR) begin
            r_out_iter    <= r_n;
            r_out_escaped <= 1'b1;
            r_out_valid   <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= S_DONE;
          end else if (r_n == r_max) begin
            r_out_iter    <= r_max;
            r_out_escaped <= 1'b0;
            r_out_valid   <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= S_DONE;
`ifdef MANDEL_OVF_ESCAPE_EN
          end else if (w_ovr || w_ovi) begin
            r_out_iter    <= w_n1;
            r_out_escaped <= 1'b1;
            r_out_valid   <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= S_DONE;
`endif
          end else begin
            r_zr    <= w_nzr;
            r_zi    <= w_nzi;
            r_sr    <= EW'(w_nzr);
            r_si    <= EW'(w_nzi);
            r_n     <= w_n1;
            r_state <= S_MULT;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_iter    = r_out_iter;
  assign out_escaped = r_out_escaped;
  assign busy        = r_busy;

endmodule

// File: tb/tb_mandelbrot_iter_unit.sv
// Directed bench for mandelbrot_iter_unit (WIDTH=12, FRAC=9, 1.0 = 512).
// Expected counts/latencies are hand-derived; latency = (k+1)*7 cycles.
module tb_mandelbrot_iter_unit;

  localparam int W  = 12;
  localparam int IT = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_cr;
  logic [W-1:0]  in_ci;
  logic [IT-1:0] in_max_iter;
  logic          out_valid;
  logic          out_ready;
  logic [IT-1:0] out_iter;
  logic          out_escaped;
  logic          busy;

  int n_chk  = 0;
  int n_fail = 0;

  mandelbrot_iter_unit #(.WIDTH(W), .FRAC(W - 3), .ITER_W(IT)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_cr       (in_cr),
    .in_ci       (in_ci),
    .in_max_iter (in_max_iter),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_iter    (out_iter),
    .out_escaped (out_escaped),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_job(input string tag, input int cr, input int ci,
                         input int mx, input int e_iter, input int e_esc,
                         input int e_lat, input int hold);
    int cyc;
    @(negedge clk);
    check({tag, ".in_ready_pre"}, 32'(in_ready), 1);
    in_cr       = W'(cr);
    in_ci       = W'(ci);
    in_max_iter = IT'(mx);
    in_valid    = 1'b1;
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    in_cr       = W'($urandom);
    in_ci       = W'($urandom);
    in_max_iter = IT'($urandom);
    check({tag, ".busy"}, 32'(busy), 1);
    check({tag, ".in_ready_run"}, 32'(in_ready), 0);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < e_lat + 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, ".latency"}, 32'(cyc), 32'(e_lat));
    check({tag, ".iter"}, 32'(out_iter), 32'(e_iter));
    check({tag, ".escaped"}, 32'(out_escaped), 32'(e_esc));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, ".hold_valid"}, 32'(out_valid), 1);
      check({tag, ".hold_iter"}, 32'(out_iter), 32'(e_iter));
      check({tag, ".hold_in_ready"}, 32'(in_ready), 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, ".valid_drop"}, 32'(out_valid), 0);
    check({tag, ".in_ready_post"}, 32'(in_ready), 1);
  endtask

  initial begin
    int seen;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_cr       = '0;
    in_ci       = '0;
    in_max_iter = '0;
    out_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.out_valid", 32'(out_valid), 0);
    check("rst.out_iter", 32'(out_iter), 0);
    check("rst.out_escaped", 32'(out_escaped), 0);
    check("rst.busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst.in_ready", 32'(in_ready), 1);

    run_job("origin", 0, 0, 20, 20, 0, 147, 0);
    run_job("minus2", -1024, 0, 50, 50, 0, 357, 0);
`ifdef MANDEL_OVF_ESCAPE_EN
    run_job("plus1", 512, 0, 50, 3, 1, 21, 0);
`else
    run_job("plus1", 512, 0, 50, 3, 1, 28, 0);
`endif
    run_job("half_half", 256, 256, 20, 5, 1, 42, 0);
    run_job("corner", -2048, -2048, 5, 1, 1, 14, 0);
    run_job("imag1_hold", 0, 512, 10, 10, 0, 77, 5);

    @(negedge clk);
    in_cr       = '0;
    in_ci       = '0;
    in_max_iter = IT'(20);
    in_valid    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst.busy", 32'(busy), 0);
    check("midrst.out_valid", 32'(out_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst.in_ready", 32'(in_ready), 1);
    seen = 0;
    repeat (160) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) seen = 1;
    end
    check("midrst.no_output", 32'(seen), 0);

    run_job("max0", 1024, 0, 0, 0, 0, 7, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
